// File: rtl/float_to_int_converter.sv
// float_to_int_converter
//   Multi-cycle conversion of an IEEE 754 single-precision operand to a signed
//   or unsigned two's-complement integer of OUT_WIDTH bits (8..32). Rounding is
//   truncate-toward-zero or round-to-nearest-even. The result saturates on
//   overflow. The converter flags overflow, NaN (invalid) and a discarded
//   fraction (inexact).
//
//   Handshake: a request is taken on a rising edge where start=1 and the FSM
//   is idle (busy=0). That edge samples a and raises busy. Four edges later,
//   result and the flags update, valid pulses high for exactly one cycle and
//   busy falls. The cycle in which valid is high can already carry the next
//   start. A start that arrives while busy is dropped and is never queued.
//
//   Ports:
//     clk       rising-edge clock
//     rst       synchronous active-high reset; aborts any conversion in flight
//     start     conversion request
//     a         float32 operand, sampled on the accepting edge only
//     busy      high from the accepting edge until the result edge
//     result    converted integer, held until the next result edge
//     valid     one-cycle pulse marking updated result/flags
//     overflow  operand out of range or +/-Inf; result is saturated
//     invalid   NaN operand; result is 0
//     inexact   nonzero fraction bits were discarded or rounded away
//     fsm_state current FSM state (0 idle, 1 unpack, 2 align, 3 round, 4 pack)
module float_to_int_converter #(
  parameter int OUT_WIDTH  = 32,
  parameter int SIGNED     = 1,
  parameter int ROUND_MODE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [31:0]          a,
  output logic                 busy,
  output logic [OUT_WIDTH-1:0] result,
  output logic                 valid,
  output logic                 overflow,
  output logic                 invalid,
  output logic                 inexact,
  output logic [2:0]           fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPACK = 3'd1,
    S_ALIGN  = 3'd2,
    S_ROUND  = 3'd3,
    S_PACK   = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    CLS_ZERO   = 3'd0,  // zero or denormal
    CLS_NAN    = 3'd1,
    CLS_INF    = 3'd2,
    CLS_BIG    = 3'd3,  // unbiased exponent >= OUT_WIDTH, always out of range
    CLS_NORMAL = 3'd4
  } cls_t;

  // Largest representable result and the most negative result.
  localparam logic [OUT_WIDTH-1:0] POS_SAT = (SIGNED != 0) ?
    {1'b0, {(OUT_WIDTH-1){1'b1}}} : {OUT_WIDTH{1'b1}};
  localparam logic [OUT_WIDTH-1:0] NEG_SAT = (SIGNED != 0) ?
    {1'b1, {(OUT_WIDTH-1){1'b0}}} : {OUT_WIDTH{1'b0}};
  // Largest legal magnitude for a positive and for a negative operand.
  localparam logic [OUT_WIDTH:0] POS_LIMIT = (SIGNED != 0) ?
    {2'b00, {(OUT_WIDTH-1){1'b1}}} : {1'b0, {OUT_WIDTH{1'b1}}};
  localparam logic [OUT_WIDTH:0] NEG_LIMIT = (SIGNED != 0) ?
    {2'b01, {(OUT_WIDTH-1){1'b0}}} : {(OUT_WIDTH+1){1'b0}};

  state_t             state;
  logic               sign_r;
  logic [7:0]         exp_r;
  logic [22:0]        frac_r;
  logic signed [9:0]  e_r;
  cls_t               cls_r;
  logic [OUT_WIDTH:0] mag_r;
  logic               guard_r;
  logic               sticky_r;
  logic               inx_r;

  assign fsm_state = state;

  // UNPACK: unbiased exponent and operand class.
  logic signed [9:0] e_n;
  cls_t              cls_n;

  always_comb begin
    e_n = $signed({2'b00, exp_r}) - 10'sd127;
    if (exp_r == 8'd0)
      cls_n = CLS_ZERO;
    else if (exp_r == 8'hFF)
      cls_n = (|frac_r) ? CLS_NAN : CLS_INF;
    else if (e_n >= $signed(10'(OUT_WIDTH)))
      cls_n = CLS_BIG;
    else
      cls_n = CLS_NORMAL;
  end

  // ALIGN: place the binary point of {1,frac} so that mag holds the integer part.
  // The guard bit is the first discarded bit. Sticky is the OR of everything
  // below the guard bit.
  logic [23:0]        mant;
  logic [4:0]         sh_l;
  logic [4:0]         sh_r;
  logic [23:0]        low_mask;
  logic [OUT_WIDTH:0] mag_n;
  logic               guard_n;
  logic               sticky_n;

  always_comb begin
    mant     = {1'b1, frac_r};
    sh_l     = 5'(e_r - 10'sd23);
    sh_r     = 5'(10'sd23 - e_r);
    low_mask = '0;
    mag_n    = '0;
    guard_n  = 1'b0;
    sticky_n = 1'b0;
    case (cls_r)
      CLS_ZERO: sticky_n = |frac_r;
      CLS_NORMAL: begin
        if (e_r >= 10'sd23) begin
          mag_n = (OUT_WIDTH+1)'({40'd0, mant} << sh_l);
        end else if (e_r >= 10'sd0) begin
          mag_n    = (OUT_WIDTH+1)'(mant >> sh_r);
          low_mask = (24'd1 << (sh_r - 5'd1)) - 24'd1;
          guard_n  = mant[sh_r - 5'd1];
          sticky_n = |(mant & low_mask);
        end else begin
          // |value| < 1: only the exponent -1 case has the hidden bit at guard.
          guard_n  = (e_r == -10'sd1);
          sticky_n = (e_r == -10'sd1) ? (|frac_r) : 1'b1;
        end
      end
      default: ;
    endcase
  end

  // ROUND: round to nearest even increments on guard and (sticky or odd lsb).
  logic round_inc;
  assign round_inc = (ROUND_MODE != 0) && guard_r && (sticky_r || mag_r[0]);

  // PACK: range check on the rounded magnitude, then apply the sign.
  logic [OUT_WIDTH-1:0] res_n;
  logic                 ov_n;
  logic                 inv_n;
  logic                 inx_n;

  always_comb begin
    res_n = '0;
    ov_n  = 1'b0;
    inv_n = 1'b0;
    inx_n = inx_r;
    case (cls_r)
      CLS_NAN: begin
        inv_n = 1'b1;
        inx_n = 1'b0;
      end
      CLS_INF, CLS_BIG: begin
        ov_n  = 1'b1;
        inx_n = 1'b0;
        res_n = sign_r ? NEG_SAT : POS_SAT;
      end
      default: begin
        if (!sign_r) begin
          if (mag_r > POS_LIMIT) begin
            ov_n  = 1'b1;
            inx_n = 1'b0;
            res_n = POS_SAT;
          end else begin
            res_n = mag_r[OUT_WIDTH-1:0];
          end
        end else begin
          // In unsigned mode NEG_LIMIT is 0, so any nonzero negative overflows to 0.
          if (mag_r > NEG_LIMIT) begin
            ov_n  = 1'b1;
            inx_n = 1'b0;
            res_n = NEG_SAT;
          end else begin
            res_n = '0 - mag_r[OUT_WIDTH-1:0];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      valid    <= 1'b0;
      overflow <= 1'b0;
      invalid  <= 1'b0;
      inexact  <= 1'b0;
      result   <= '0;
      sign_r   <= 1'b0;
      exp_r    <= '0;
      frac_r   <= '0;
      e_r      <= '0;
      cls_r    <= CLS_ZERO;
      mag_r    <= '0;
      guard_r  <= 1'b0;
      sticky_r <= 1'b0;
      inx_r    <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !busy) begin
            sign_r   <= a[31];
            exp_r    <= a[30:23];
            frac_r   <= a[22:0];
            overflow <= 1'b0;
            invalid  <= 1'b0;
            inexact  <= 1'b0;
            busy     <= 1'b1;
            state    <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          e_r   <= e_n;
          cls_r <= cls_n;
          state <= S_ALIGN;
        end
        S_ALIGN: begin
          mag_r    <= mag_n;
          guard_r  <= guard_n;
          sticky_r <= sticky_n;
          state    <= S_ROUND;
        end
        S_ROUND: begin
          mag_r <= mag_r + (OUT_WIDTH+1)'(round_inc);
          inx_r <= guard_r | sticky_r;
          state <= S_PACK;
        end
        S_PACK: begin
          result   <= res_n;
          overflow <= ov_n;
          invalid  <= inv_n;
          inexact  <= inx_n;
          valid    <= 1'b1;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_float_to_int_converter.sv
// Testbench for float_to_int_converter. Four instances share clk/rst/start/a:
//   rne : 32-bit signed, round to nearest even (default parameters)
//   trn : 32-bit signed, truncate
//   uns : 32-bit unsigned, round to nearest even
//   w8  : 8-bit signed, round to nearest even
// Every conversion is checked on all four against a value-level reference model.
module tb_float_to_int_converter;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a;

  always #5 clk = ~clk;

  logic        busy_rne, valid_rne, ov_rne, inv_rne, inx_rne;
  logic [31:0] res_rne;
  logic [2:0]  st_rne;
  logic        busy_trn, valid_trn, ov_trn, inv_trn, inx_trn;
  logic [31:0] res_trn;
  logic [2:0]  st_trn;
  logic        busy_uns, valid_uns, ov_uns, inv_uns, inx_uns;
  logic [31:0] res_uns;
  logic [2:0]  st_uns;
  logic        busy_w8, valid_w8, ov_w8, inv_w8, inx_w8;
  logic [7:0]  res_w8;
  logic [2:0]  st_w8;

  float_to_int_converter u_rne (
    .clk(clk), .rst(rst), .start(start), .a(a), .busy(busy_rne), .result(res_rne),
    .valid(valid_rne), .overflow(ov_rne), .invalid(inv_rne), .inexact(inx_rne),
    .fsm_state(st_rne));

  float_to_int_converter #(.OUT_WIDTH(32), .SIGNED(1), .ROUND_MODE(0)) u_trn (
    .clk(clk), .rst(rst), .start(start), .a(a), .busy(busy_trn), .result(res_trn),
    .valid(valid_trn), .overflow(ov_trn), .invalid(inv_trn), .inexact(inx_trn),
    .fsm_state(st_trn));

  float_to_int_converter #(.OUT_WIDTH(32), .SIGNED(0), .ROUND_MODE(1)) u_uns (
    .clk(clk), .rst(rst), .start(start), .a(a), .busy(busy_uns), .result(res_uns),
    .valid(valid_uns), .overflow(ov_uns), .invalid(inv_uns), .inexact(inx_uns),
    .fsm_state(st_uns));

  float_to_int_converter #(.OUT_WIDTH(8), .SIGNED(1), .ROUND_MODE(1)) u_w8 (
    .clk(clk), .rst(rst), .start(start), .a(a), .busy(busy_w8), .result(res_w8),
    .valid(valid_w8), .overflow(ov_w8), .invalid(inv_w8), .inexact(inx_w8),
    .fsm_state(st_w8));

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cur_a;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s (a=%h): got %h expected %h", name, cur_a, act, want);
    end
  endtask

  // ---------------- reference model ----------------
  // Works on the exact real value: integer part plus remainder, with the
  // remainder compared against one half for round-to-nearest-even.
  typedef struct packed {
    logic [31:0] res;
    logic        ov;
    logic        inv;
    logic        inx;
  } ref_t;

  function automatic ref_t ref_conv(input logic [31:0] f, input int w, input bit sgn,
                                    input bit rne);
    ref_t        r;
    longint      mant, mag, rem, half, v, hi, lo;
    logic [63:0] mask, vbits;
    int          e, d;
    bit          huge;
    r    = '0;
    huge = 1'b0;
    mag  = 0;
    mant = longint'({1'b1, f[22:0]});
    if (f[30:23] == 8'hFF && f[22:0] != 23'd0) begin
      r.inv = 1'b1;
      return r;
    end
    if (f[30:23] == 8'hFF) begin
      huge = 1'b1;
    end else if (f[30:23] == 8'd0) begin
      r.inx = (f[22:0] != 23'd0);
    end else begin
      e = int'(f[30:23]) - 127;
      if (e > 40) begin
        huge = 1'b1;
      end else if (e >= 23) begin
        mag = mant << (e - 23);
      end else begin
        d = 23 - e;
        if (d > 40) begin
          r.inx = 1'b1;  // far below one half
        end else begin
          mag   = mant >> d;
          rem   = mant - (mag << d);
          half  = longint'(1) << (d - 1);
          r.inx = (rem != 0);
          if (rne && (rem > half || (rem == half && mag[0]))) mag = mag + 1;
        end
      end
    end
    hi = sgn ? (longint'(1) << (w - 1)) - 1 : (longint'(1) << w) - 1;
    lo = sgn ? -(longint'(1) << (w - 1)) : 0;
    v  = f[31] ? -mag : mag;
    if (huge) v = f[31] ? lo - 1 : hi + 1;
    if (v > hi) begin
      v = hi; r.ov = 1'b1; r.inx = 1'b0;
    end else if (v < lo) begin
      v = lo; r.ov = 1'b1; r.inx = 1'b0;
    end
    mask  = (64'd1 << w) - 64'd1;
    vbits = 64'(v) & mask;
    r.res = vbits[31:0];
    return r;
  endfunction

  task automatic check_inst(input string tag, input logic [31:0] f, input int w,
                            input bit sgn, input bit rne, input logic [31:0] res,
                            input logic ov, input logic inv, input logic inx,
                            input logic vld);
    ref_t r;
    r = ref_conv(f, w, sgn, rne);
    chk({tag, ".valid"},    32'(vld), 32'd1);
    chk({tag, ".result"},   res,      r.res);
    chk({tag, ".overflow"}, 32'(ov),  32'(r.ov));
    chk({tag, ".invalid"},  32'(inv), 32'(r.inv));
    chk({tag, ".inexact"},  32'(inx), 32'(r.inx));
  endtask

  // ---------------- driver ----------------
  // Issues one request and waits (bounded) for valid, then checks all instances.
  task automatic run_one(input logic [31:0] f);
    int n;
    cur_a = f;
    @(negedge clk);
    start = 1'b1;
    a     = f;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;  // operand must be ignored after acceptance
    chk("busy_after_accept", 32'(busy_rne), 32'd1);
    chk("valid_low_after_accept", 32'(valid_rne), 32'd0);
    n = 0;
    while (valid_rne !== 1'b1 && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", 32'(n), 32'd4);
    chk("busy_low_at_valid", 32'(busy_rne), 32'd0);
    check_inst("rne", f, 32, 1'b1, 1'b1, res_rne, ov_rne, inv_rne, inx_rne, valid_rne);
    check_inst("trn", f, 32, 1'b1, 1'b0, res_trn, ov_trn, inv_trn, inx_trn, valid_trn);
    check_inst("uns", f, 32, 1'b0, 1'b1, res_uns, ov_uns, inv_uns, inx_uns, valid_uns);
    check_inst("w8",  f, 8,  1'b1, 1'b1, {24'd0, res_w8}, ov_w8, inv_w8, inx_w8, valid_w8);
  endtask

  // ---------------- directed vectors (default instance) ----------------
  typedef struct packed {
    logic [31:0] f;
    logic [31:0] res;
    logic        ov;
    logic        inv;
    logic        inx;
  } vec_t;

  vec_t tbl [17];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          nv;
    logic [31:0] res_seen;
    logic [31:0] f;
    int          kind;

    tbl[0]  = '{32'h40600000, 32'h00000004, 1'b0, 1'b0, 1'b1};  // 3.5
    tbl[1]  = '{32'hC0200000, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1};  // -2.5
    tbl[2]  = '{32'h3F000000, 32'h00000000, 1'b0, 1'b0, 1'b1};  // 0.5
    tbl[3]  = '{32'h4F000000, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0};  // 2^31
    tbl[4]  = '{32'hCF000000, 32'h80000000, 1'b0, 1'b0, 1'b0};  // -2^31
    tbl[5]  = '{32'h7FC00000, 32'h00000000, 1'b0, 1'b1, 1'b0};  // NaN
    tbl[6]  = '{32'hFF800000, 32'h80000000, 1'b1, 1'b0, 1'b0};  // -Inf
    tbl[7]  = '{32'h00000001, 32'h00000000, 1'b0, 1'b0, 1'b1};  // denormal
    tbl[8]  = '{32'h40490FDB, 32'h00000003, 1'b0, 1'b0, 1'b1};  // pi
    tbl[9]  = '{32'h3F800000, 32'h00000001, 1'b0, 1'b0, 1'b0};  // 1.0
    tbl[10] = '{32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0};  // +0
    tbl[11] = '{32'h3FC00000, 32'h00000002, 1'b0, 1'b0, 1'b1};  // 1.5
    tbl[12] = '{32'h4B000001, 32'h00800001, 1'b0, 1'b0, 1'b0};  // 2^23+1
    tbl[13] = '{32'h7F800000, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0};  // +Inf
    tbl[14] = '{32'h3E800000, 32'h00000000, 1'b0, 1'b0, 1'b1};  // 0.25
    tbl[15] = '{32'h3F400000, 32'h00000001, 1'b0, 1'b0, 1'b1};  // 0.75
    tbl[16] = '{32'hC1200000, 32'hFFFFFFF6, 1'b0, 1'b0, 1'b0};  // -10

    // ---- reset state ----
    cur_a = 32'd0;
    rst   = 1'b1;
    start = 1'b0;
    a     = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy",     32'(busy_rne), 32'd0);
    chk("rst.valid",    32'(valid_rne), 32'd0);
    chk("rst.result",   res_rne, 32'd0);
    chk("rst.overflow", 32'(ov_rne), 32'd0);
    chk("rst.invalid",  32'(inv_rne), 32'd0);
    chk("rst.inexact",  32'(inx_rne), 32'd0);
    chk("rst.state",    32'(st_rne), 32'd0);
    chk("rst.w8_result", {24'd0, res_w8}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // ---- directed table (back-to-back requests, start in the valid cycle) ----
    for (int i = 0; i < 17; i++) begin
      run_one(tbl[i].f);
      chk("tbl.result",   res_rne, tbl[i].res);
      chk("tbl.overflow", 32'(ov_rne), 32'(tbl[i].ov));
      chk("tbl.invalid",  32'(inv_rne), 32'(tbl[i].inv));
      chk("tbl.inexact",  32'(inx_rne), 32'(tbl[i].inx));
    end

    // ---- variant-specific corner cases ----
    run_one(32'h40490FDB);
    chk("trunc_pi.result",  res_trn, 32'd3);
    chk("trunc_pi.inexact", 32'(inx_trn), 32'd1);
    run_one(32'hBF800000);
    chk("uns_neg1.result",   res_uns, 32'd0);
    chk("uns_neg1.overflow", 32'(ov_uns), 32'd1);
    run_one(32'h4F800000);
    chk("uns_2p32.result",   res_uns, 32'hFFFFFFFF);
    chk("uns_2p32.overflow", 32'(ov_uns), 32'd1);
    run_one(32'h42FF0000);
    chk("w8_127p5.result",   {24'd0, res_w8}, 32'h7F);
    chk("w8_127p5.overflow", 32'(ov_w8), 32'd1);
    chk("w8_127p5.inexact",  32'(inx_w8), 32'd0);
    run_one(32'hC3000000);  // -128 fits 8-bit signed exactly
    chk("w8_m128.result",   {24'd0, res_w8}, 32'h80);
    chk("w8_m128.overflow", 32'(ov_w8), 32'd0);

    // ---- start pulsed during ALIGN is ignored ----
    cur_a = 32'h41200000;
    @(negedge clk);
    start = 1'b1;
    a     = 32'h41200000;  // 10.0
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("busy_start.state_align", 32'(st_rne), 32'd2);
    start = 1'b1;
    a     = 32'h3F800000;
    @(negedge clk);
    start = 1'b0;
    nv       = 0;
    res_seen = 32'hDEADBEEF;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (valid_rne === 1'b1) begin
        nv++;
        res_seen = res_rne;
      end
    end
    chk("busy_start.valid_count", 32'(nv), 32'd1);
    chk("busy_start.result", res_seen, 32'd10);

    // ---- reset asserted in ROUND aborts the conversion ----
    cur_a = 32'h40600000;
    @(negedge clk);
    start = 1'b1;
    a     = 32'h40600000;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("abort.state_round", 32'(st_rne), 32'd3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort.busy",  32'(busy_rne), 32'd0);
    chk("abort.valid", 32'(valid_rne), 32'd0);
    chk("abort.state", 32'(st_rne), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    nv  = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (valid_rne === 1'b1 || valid_trn === 1'b1 || valid_uns === 1'b1 ||
          valid_w8 === 1'b1) nv++;
    end
    chk("abort.no_late_valid", 32'(nv), 32'd0);
    run_one(32'h40600000);
    chk("after_abort.result", res_rne, 32'd4);

    // ---- randomized operands against the reference model ----
    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        f = $urandom;
      end else if (kind == 1) begin
        f = {1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00,
             23'($urandom_range(0, 3) == 0 ? 0 : $urandom)};
      end else if (kind == 2) begin
        // Few fraction bits: exact values and exact ties are common.
        f = {1'($urandom_range(0, 1)), 8'($urandom_range(120, 140)),
             23'($urandom_range(0, 255) << 15)};
      end else begin
        f = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 162)), 23'($urandom)};
      end
      run_one(f);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
